// File: rtl/multi_mode_seq_divider.sv
// rtl/multi_mode_seq_divider.sv - parametrised sequential radix-2 restoring divider (signed/unsigned)
//
// Ports:
//   clk, reset          single clock, synchronous active-high reset
//   start               request; accepted in IDLE or DONE
//   signed_op           two's-complement operands (ignored when SIGNED_EN = 0)
//   dividend, divisor   operands, sampled with an accepted start
//   busy                high in PREP, ITER, FIX
//   done                one-cycle pulse when results are valid
//   quotient, remainder results, held between completions
//   div_by_zero         divisor was zero
//   overflow            signed most-negative / -1
`timescale 1ns/1ps
module multi_mode_seq_divider #(
    parameter int WIDTH     = 64,
    parameter bit SIGNED_EN = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             signed_op,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero,
    output logic             overflow
);

    localparam int             CW       = $clog2(WIDTH);
    localparam logic [CW-1:0]  LAST_CNT = CW'(WIDTH - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PREP,
        S_ITER,
        S_FIX,
        S_DONE
    } state_t;

    state_t state, state_next;

    // Captured operands and mode; a_r/b_r keep the original bits for the
    // zero-divisor and overflow cases.
    logic [WIDTH-1:0] a_r, b_r;
    logic             sgn_r, a_neg, b_neg;

    // Iteration state: quo holds the dividend magnitude and shifts in
    // quotient bits from the right as the dividend bits shift out the left.
    logic [WIDTH-1:0] quo, rem, b_mag;
    logic [CW-1:0]    cnt;

    logic [WIDTH:0]   rem_sh;
    logic [WIDTH+1:0] trial;
    logic             trial_ok;
    logic             unused_trial_bit;

    logic [WIDTH-1:0] q_fix, r_fix;
    logic             dz_fix, ov_fix;

    // FSM next state and status outputs
    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            S_IDLE: if (start) state_next = S_PREP;
            S_PREP: begin
                busy       = 1'b1;
                state_next = S_ITER;
            end
            S_ITER: begin
                busy = 1'b1;
                if (cnt == '0) state_next = S_FIX;
            end
            S_FIX: begin
                busy       = 1'b1;
                state_next = S_DONE;
            end
            S_DONE: begin
                done       = 1'b1;
                state_next = start ? S_PREP : S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    // One restoring step. The partial remainder is always below the divisor
    // magnitude, so after the shift it fits in WIDTH+1 bits; the extra top
    // bit of the subtract is the borrow.
    always_comb begin
        rem_sh           = {rem, quo[WIDTH-1]};
        trial            = {1'b0, rem_sh} - {2'b00, b_mag};
        trial_ok         = ~trial[WIDTH+1];
        // When the subtract succeeds the difference is below the divisor,
        // so bit WIDTH is always zero and never needs to be kept.
        unused_trial_bit = trial[WIDTH];
    end

    // Sign fix-up and special cases, registered on the FIX -> DONE edge
    always_comb begin
        dz_fix = (b_r == '0);
        ov_fix = sgn_r && (a_r == {1'b1, {(WIDTH-1){1'b0}}}) && (b_r == '1);
        if (dz_fix) begin
            q_fix = '1;
            r_fix = a_r;
        end else begin
            q_fix = (a_neg ^ b_neg) ? -quo : quo;
            r_fix = a_neg ? -rem : rem;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_IDLE;
            a_r         <= '0;
            b_r         <= '0;
            sgn_r       <= 1'b0;
            a_neg       <= 1'b0;
            b_neg       <= 1'b0;
            quo         <= '0;
            rem         <= '0;
            b_mag       <= '0;
            cnt         <= '0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            state <= state_next;
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        a_r   <= dividend;
                        b_r   <= divisor;
                        sgn_r <= SIGNED_EN && signed_op;
                        a_neg <= SIGNED_EN && signed_op && dividend[WIDTH-1];
                        b_neg <= SIGNED_EN && signed_op && divisor[WIDTH-1];
                    end
                end
                S_PREP: begin
                    quo   <= a_neg ? -a_r : a_r;
                    b_mag <= b_neg ? -b_r : b_r;
                    rem   <= '0;
                    cnt   <= LAST_CNT;
                end
                S_ITER: begin
                    quo <= {quo[WIDTH-2:0], trial_ok};
                    rem <= trial_ok ? trial[WIDTH-1:0] : rem_sh[WIDTH-1:0];
                    cnt <= cnt - 1'b1;
                end
                S_FIX: begin
                    quotient    <= q_fix;
                    remainder   <= r_fix;
                    div_by_zero <= dz_fix;
                    overflow    <= ov_fix;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_multi_mode_seq_divider.sv
// tb/tb_multi_mode_seq_divider.sv - directed self-checking bench for multi_mode_seq_divider
`timescale 1ns/1ps
module tb_multi_mode_seq_divider;

    logic        clk = 1'b0;
    logic        reset;
    logic        start, signed_op;
    logic [63:0] dividend, divisor;
    logic        busy, done;
    logic [63:0] quotient, remainder;
    logic        div_by_zero, overflow;

    logic        s_start, s_signed_op;
    logic [7:0]  s_dividend, s_divisor;
    logic        s_busy, s_done;
    logic [7:0]  s_quotient, s_remainder;
    logic        s_div_by_zero, s_overflow;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    multi_mode_seq_divider #(.WIDTH(64), .SIGNED_EN(1'b1)) dut (
        .clk(clk), .reset(reset), .start(start), .signed_op(signed_op),
        .dividend(dividend), .divisor(divisor), .busy(busy), .done(done),
        .quotient(quotient), .remainder(remainder),
        .div_by_zero(div_by_zero), .overflow(overflow)
    );

    multi_mode_seq_divider #(.WIDTH(8), .SIGNED_EN(1'b1)) dut8 (
        .clk(clk), .reset(reset), .start(s_start), .signed_op(s_signed_op),
        .dividend(s_dividend), .divisor(s_divisor), .busy(s_busy), .done(s_done),
        .quotient(s_quotient), .remainder(s_remainder),
        .div_by_zero(s_div_by_zero), .overflow(s_overflow)
    );

    // Issue a one-cycle start (caller sits 1 ns after an edge) and count
    // edges from the accepting edge until done is seen (bounded).
    task automatic run64(input logic [63:0] a, input logic [63:0] b, input logic s,
                         output int lat, output logic busy_after);
        dividend = a; divisor = b; signed_op = s; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        busy_after = busy;
        lat = 0;
        while (done !== 1'b1 && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic test_reset;
        n_cmp++;
        if ({busy, done, quotient, remainder, div_by_zero, overflow} !== '0) begin
            n_fail++;
            $display("FAIL reset_state: busy=%b done=%b q=%h r=%h z=%b o=%b, required all zero",
                     busy, done, quotient, remainder, div_by_zero, overflow);
        end
    endtask

    task automatic test_unsigned;
        int lat; logic ba;
        run64(64'd765, 64'd63, 1'b0, lat, ba);
        n_cmp++;
        if (ba !== 1'b1) begin n_fail++; $display("FAIL busy_after_start: got %b, required 1", ba); end
        n_cmp++;
        if (lat != 66) begin n_fail++; $display("FAIL latency_765_63: got %0d, required 66", lat); end
        n_cmp++;
        if ({quotient, remainder, div_by_zero, overflow} !== {64'd12, 64'd9, 2'b00}) begin
            n_fail++;
            $display("FAIL unsigned_765_63: got q=%0d r=%0d z=%b o=%b, required q=12 r=9 z=0 o=0",
                     quotient, remainder, div_by_zero, overflow);
        end
        @(posedge clk); #1;
        n_cmp++;
        if ({done, busy} !== 2'b00) begin
            n_fail++;
            $display("FAIL done_pulse_width: got done=%b busy=%b one cycle later, required 0 0", done, busy);
        end
    endtask

    task automatic test_signed;
        int lat; logic ba;
        run64(-64'sd7, 64'd2, 1'b1, lat, ba);
        n_cmp++;
        if ({quotient, remainder, overflow} !== {64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0}) begin
            n_fail++;
            $display("FAIL signed_m7_2: got q=%h r=%h o=%b, required q=fffffffffffffffd r=ffffffffffffffff o=0",
                     quotient, remainder, overflow);
        end
        run64(64'd7, -64'sd2, 1'b1, lat, ba);
        n_cmp++;
        if ({quotient, remainder} !== {64'hFFFF_FFFF_FFFF_FFFD, 64'd1}) begin
            n_fail++;
            $display("FAIL signed_7_m2: got q=%h r=%h, required q=fffffffffffffffd r=1", quotient, remainder);
        end
        run64(64'd7, 64'd2, 1'b0, lat, ba);
        n_cmp++;
        if ({quotient, remainder, overflow} !== {64'd3, 64'd1, 1'b0}) begin
            n_fail++;
            $display("FAIL unsigned_7_2: got q=%0d r=%0d o=%b, required q=3 r=1 o=0", quotient, remainder, overflow);
        end
    endtask

    task automatic test_div_zero;
        int lat; logic ba;
        run64(64'd1234, 64'd0, 1'b0, lat, ba);
        n_cmp++;
        if (lat != 66) begin n_fail++; $display("FAIL latency_div_zero: got %0d, required 66", lat); end
        n_cmp++;
        if ({quotient, remainder, div_by_zero, overflow} !== {64'hFFFF_FFFF_FFFF_FFFF, 64'd1234, 2'b10}) begin
            n_fail++;
            $display("FAIL div_zero_1234: got q=%h r=%0d z=%b o=%b, required q=ffffffffffffffff r=1234 z=1 o=0",
                     quotient, remainder, div_by_zero, overflow);
        end
        run64(64'd10, 64'd3, 1'b0, lat, ba);
        n_cmp++;
        if ({quotient, remainder, div_by_zero} !== {64'd3, 64'd1, 1'b0}) begin
            n_fail++;
            $display("FAIL after_div_zero_10_3: got q=%0d r=%0d z=%b, required q=3 r=1 z=0",
                     quotient, remainder, div_by_zero);
        end
        run64(-64'sd5, 64'd0, 1'b1, lat, ba);
        n_cmp++;
        if ({quotient, remainder, div_by_zero, overflow} !== {64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFB, 2'b10}) begin
            n_fail++;
            $display("FAIL signed_div_zero_m5: got q=%h r=%h z=%b o=%b, required q=ffffffffffffffff r=fffffffffffffffb z=1 o=0",
                     quotient, remainder, div_by_zero, overflow);
        end
    endtask

    task automatic test_overflow;
        int lat; logic ba;
        run64(64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, lat, ba);
        n_cmp++;
        if ({quotient, remainder, div_by_zero, overflow} !== {64'h8000_0000_0000_0000, 64'd0, 2'b01}) begin
            n_fail++;
            $display("FAIL signed_overflow: got q=%h r=%h z=%b o=%b, required q=8000000000000000 r=0 z=0 o=1",
                     quotient, remainder, div_by_zero, overflow);
        end
        run64(64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, lat, ba);
        n_cmp++;
        if ({quotient, remainder, overflow} !== {64'd0, 64'h8000_0000_0000_0000, 1'b0}) begin
            n_fail++;
            $display("FAIL unsigned_no_overflow: got q=%h r=%h o=%b, required q=0 r=8000000000000000 o=0",
                     quotient, remainder, overflow);
        end
    endtask

    task automatic test_back_to_back;
        logic [63:0] ta [3];
        logic [63:0] tb [3];
        logic        ts [3];
        logic [63:0] tq [3];
        logic [63:0] tr [3];
        int lat;
        ta[0] = 64'd1000; tb[0] = 64'd10; ts[0] = 1'b0; tq[0] = 64'd100; tr[0] = 64'd0;
        ta[1] = 64'd77;   tb[1] = 64'd5;  ts[1] = 1'b0; tq[1] = 64'd15;  tr[1] = 64'd2;
        ta[2] = -64'sd100; tb[2] = 64'd7; ts[2] = 1'b1;
        tq[2] = 64'hFFFF_FFFF_FFFF_FFF2; tr[2] = 64'hFFFF_FFFF_FFFF_FFFE;
        dividend = ta[0]; divisor = tb[0]; signed_op = ts[0]; start = 1'b1;
        for (int op = 0; op < 3; op++) begin
            @(posedge clk); #1;
            n_cmp++;
            if (busy !== 1'b1) begin n_fail++; $display("FAIL b2b_accept_%0d: busy=%b, required 1", op, busy); end
            lat = 0;
            while (done !== 1'b1 && lat < 200) begin
                // Junk operands while busy must not disturb the operation.
                dividend = 64'hDEAD_BEEF_0000_0000 + 64'(lat);
                divisor  = 64'(lat);
                signed_op = lat[0];
                @(posedge clk); #1;
                lat++;
                if (op > 0 && lat == 30) begin
                    n_cmp++;
                    if (quotient !== tq[op-1]) begin
                        n_fail++;
                        $display("FAIL b2b_hold_%0d: quotient=%h mid-op, required %h", op, quotient, tq[op-1]);
                    end
                end
            end
            n_cmp++;
            if (lat != 66) begin n_fail++; $display("FAIL b2b_latency_%0d: got %0d, required 66", op, lat); end
            n_cmp++;
            if ({quotient, remainder} !== {tq[op], tr[op]}) begin
                n_fail++;
                $display("FAIL b2b_result_%0d: got q=%h r=%h, required q=%h r=%h", op, quotient, remainder, tq[op], tr[op]);
            end
            if (op < 2) begin
                dividend = ta[op+1]; divisor = tb[op+1]; signed_op = ts[op+1];
            end
        end
        start = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid;
        int lat; logic ba; int seen;
        dividend = 64'd5000; divisor = 64'd3; signed_op = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (20) begin @(posedge clk); #1; end
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        n_cmp++;
        if ({busy, done, quotient, remainder, div_by_zero, overflow} !== '0) begin
            n_fail++;
            $display("FAIL reset_mid_op: busy=%b done=%b q=%h r=%h z=%b o=%b, required all zero",
                     busy, done, quotient, remainder, div_by_zero, overflow);
        end
        seen = 0;
        repeat (80) begin
            @(posedge clk); #1;
            if (done === 1'b1) seen++;
        end
        n_cmp++;
        if (seen != 0) begin n_fail++; $display("FAIL no_done_after_reset: saw %0d done cycles, required 0", seen); end
        run64(64'd100, 64'd7, 1'b0, lat, ba);
        n_cmp++;
        if ({quotient, remainder} !== {64'd14, 64'd2} || lat != 66) begin
            n_fail++;
            $display("FAIL after_reset_100_7: got q=%0d r=%0d lat=%0d, required q=14 r=2 lat=66", quotient, remainder, lat);
        end
    endtask

    task automatic test_width8;
        int lat;
        s_dividend = 8'd200; s_divisor = 8'd7; s_signed_op = 1'b0; s_start = 1'b1;
        @(posedge clk); #1;
        s_start = 1'b0;
        lat = 0;
        while (s_done !== 1'b1 && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        n_cmp++;
        if (lat != 10) begin n_fail++; $display("FAIL w8_latency: got %0d, required 10", lat); end
        n_cmp++;
        if ({s_quotient, s_remainder, s_div_by_zero, s_overflow} !== {8'd28, 8'd4, 2'b00}) begin
            n_fail++;
            $display("FAIL w8_200_7: got q=%0d r=%0d z=%b o=%b, required q=28 r=4 z=0 o=0",
                     s_quotient, s_remainder, s_div_by_zero, s_overflow);
        end
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; signed_op = 1'b0; dividend = '0; divisor = '0;
        s_start = 1'b0; s_signed_op = 1'b0; s_dividend = '0; s_divisor = '0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        test_reset();
        test_unsigned();
        test_signed();
        test_div_zero();
        test_overflow();
        test_back_to_back();
        test_reset_mid();
        test_width8();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/multi_mode_seq_divider.md
# multi_mode_seq_divider

Parametrised sequential radix-2 restoring divider, the successor to the fixed 64-bit-operand/32-bit-quotient binary divider. It generalises operand width, adds signed/unsigned mode per operation, and produces a remainder alongside the quotient. It adds divide-by-zero and signed-overflow flags and a start/busy/done handshake that supports back-to-back operations. It sits in the datapath wherever a multi-cycle integer divide is issued by a controlling FSM.

## Interface
- WIDTH, 64, dividend/divisor/quotient/remainder width in bits (≥ 2)
- SIGNED_EN, 1, 1 = honour `signed_op`; 0 = `signed_op` ignored, all operations unsigned
- clk  in  1  single clock, all logic on rising edge
- reset  in  1  synchronous, active-high; one clock, one reset (fixed)
- start  in  1  request; accepted on a rising edge when state is IDLE or DONE
- signed_op  in  1  operands are two's complement (sampled with start)
- dividend  in  WIDTH  numerator (sampled with start)
- divisor  in  WIDTH  denominator (sampled with start)
- busy  out  1  high in PREP, ITER, FIX
- done  out  1  one-cycle pulse; results valid
- quotient  out  WIDTH  result, held until the next accepted start
- remainder  out  WIDTH  result, held until the next accepted start
- div_by_zero  out  1  divisor was 0; valid with done, held like results
- overflow  out  1  signed most-negative / -1; valid with done, held

## Operation
- States: IDLE, PREP, ITER, FIX, DONE.
- IDLE/DONE + start → PREP: capture operands, mode, and sign bits (signed mode only). Clear done.
- PREP → ITER: convert to magnitudes (negate negative operands in signed mode). Clear the partial remainder. Load the iteration counter with WIDTH-1.
- ITER: each cycle shift {rem, quo} left by 1. Trial-subtract the divisor magnitude using a WIDTH+1-bit subtract. If the result is non-negative, keep it and set quo LSB = 1. The counter decrements. At counter 0 → FIX.
- FIX → DONE: apply signs, then register outputs and flags. Pulse done.
  - Quotient is negated if the operand signs differ.
  - Remainder takes the dividend's sign. Rounding truncates toward zero.
- DONE → IDLE next cycle unless start is high, in which case → PREP.
- Divisor = 0: the full latency still runs. quotient = all ones, remainder = original dividend (unmodified bits), div_by_zero = 1, overflow = 0.
- Signed, dividend = 100…0 and divisor = all ones: quotient = 100…0, remainder = 0, overflow = 1.
- Unsigned mode never sets overflow.
- start while busy: ignored; the operation in flight is undisturbed.
- Reset (any state, including mid-ITER): → IDLE next edge.
  - busy, done, div_by_zero, overflow = 0.
  - quotient, remainder = 0.
  - Internal registers are cleared.

## Timing
- Start accepted at edge k. busy = 1 after edge k. done = 1 after edge k+WIDTH+2 for exactly one cycle. Latency = WIDTH+2 cycles (66 for WIDTH=64).
- busy falls on the same edge that done rises.
- Back-to-back: start high during the done cycle is accepted. The next done comes WIDTH+2 cycles later, with no idle gap.
- Outputs and flags update only at the FIX→DONE edge. They are stable at all other times.
- No combinational path from inputs to outputs.

## Test plan
- Unsigned, WIDTH=64: dividend 765, divisor 63, 1-cycle start pulse after reset → done exactly 66 cycles later; quotient 12, remainder 9, both flags 0.
- Signed: -7 / 2 → quotient -2^64+... i.e. -3 (0xFFFF_FFFF_FFFF_FFFD), remainder -1. Then 7 / -2 → quotient -3, remainder 1. Then 7 / 2 with signed_op=0 → 3 r 1.
- Divide by zero: 1234 / 0 → quotient all ones, remainder 1234, div_by_zero = 1, same 66-cycle latency. A following 10 / 3 clears the flag (3 r 1).
- Signed overflow: 0x8000_0000_0000_0000 / -1 → quotient 0x8000_0000_0000_0000, remainder 0, overflow = 1.
- Handshake: start held high continuously with changing operands. Inputs presented during busy are ignored. Each done is followed by acceptance in the done cycle, giving one result per 66 cycles.
- Reset mid-op: assert reset 20 cycles into a divide → all outputs 0 next edge, and no done appears. A new 100 / 7 afterwards gives 14 r 2. Also repeat the first scenario at WIDTH=8 (200 / 7 → 28 r 4, latency 10).
